ace_clock_reset_gen: RTL and testbench

Single-clock timing and reset generator for the Jupiter ACE system. It replaces the multi-output PLL clock tree (separate RAM, VGA, video and CPU clocks) with one master clock plus derived single-cycle clock enables. It adds a switchable turbo CPU rate and a CPU wait-state input. It also replaces the fixed 8-stage power-on shift register with a parametrised, debounced, multi-source reset sequencer feeding the core, keyboard and scandoubler.

---
 rtl/ace_clock_reset_gen.sv | 196 +++++++++++++++++++
 tb/tb_ace_clock_reset_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ace_clock_reset_gen.sv
`default_nettype none
// ============================================================================
// Module      : ace_clock_reset_gen
// Description : Single-clock timing and reset generator for the Jupiter ACE.
//               One master clock drives everything; the scandoubler, video
//               and CPU run from single-cycle clock enables derived from it.
//               Includes a switchable turbo CPU rate, a CPU wait-state
//               input and a debounced multi-source power-on reset sequencer.
//
// Ports       :
//   clk          in   master clock (the only clock in the block)
//   reset        in   synchronous active-high master reset
//   rst_req_n    in   [NUM_RST_SRC] active-low reset requests, async to clk
//   turbo        in   turbo CPU rate request, async level
//   cpu_wait     in   synchronous stall, suppresses ce_cpu while high
//   ce_vga       out  enable at twice the pixel rate (scandoubler)
//   ce_pix       out  pixel / video enable
//   ce_cpu       out  CPU enable
//   sys_reset    out  active-high system reset
//   core_reset_n out  active-low copy of sys_reset
//   turbo_active out  1 = turbo CPU divider currently in use
//
// Revision    : 1.0 - initial release
// ============================================================================
module ace_clock_reset_gen #(
    parameter int PIX_DIV        = 4,   // master clocks per pixel enable, even, >= 2
    parameter int CPU_DIV_NORMAL = 2,   // pixel enables per CPU enable, normal rate
    parameter int CPU_DIV_TURBO  = 1,   // pixel enables per CPU enable, turbo rate
    parameter int POR_CYCLES     = 8,   // pixel enables of reset after causes clear
    parameter int NUM_RST_SRC    = 2,   // number of external reset requests
    parameter int DEB_CYCLES     = 16   // clk cycles a request must persist
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RST_SRC-1:0] rst_req_n,
    input  logic                   turbo,
    input  logic                   cpu_wait,
    output logic                   ce_vga,
    output logic                   ce_pix,
    output logic                   ce_cpu,
    output logic                   sys_reset,
    output logic                   core_reset_n,
    output logic                   turbo_active
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
    localparam int c_CPU_W = $clog2(CPU_DIV_NORMAL + 1);
    localparam int c_POR_W = $clog2(POR_CYCLES + 1);
    localparam int c_DEB_W = $clog2(DEB_CYCLES + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(PIX_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_HALF_LAST = c_DIV_W'(PIX_DIV / 2 - 1);
    localparam logic [c_CPU_W-1:0] c_CPU_LAST_NORMAL = c_CPU_W'(CPU_DIV_NORMAL - 1);
    localparam logic [c_CPU_W-1:0] c_CPU_LAST_TURBO  = c_CPU_W'(CPU_DIV_TURBO - 1);
    localparam logic [c_POR_W-1:0] c_POR_DONE = c_POR_W'(POR_CYCLES);
    localparam logic [c_DEB_W-1:0] c_DEB_DONE = c_DEB_W'(DEB_CYCLES);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0]     r_div_cnt;
    logic [c_CPU_W-1:0]     r_cpu_cnt;
    logic [c_POR_W-1:0]     r_por_cnt;
    logic [c_DEB_W-1:0]     r_deb_cnt;
    logic                   r_turbo_meta;
    logic                   r_turbo_sync;
    logic                   r_turbo_active;
    // Request synchronisers hold the inverted (active-high) request so that
    // their reset value of 0 means "no request pending".
    logic [NUM_RST_SRC-1:0] r_req_meta;
    logic [NUM_RST_SRC-1:0] r_req_sync;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                   w_ce_pix;
    logic                   w_ce_vga;
    logic                   w_ce_cpu;
    logic [c_CPU_W-1:0]     w_cpu_last;
    logic                   w_cpu_at_last;
    logic                   w_any_req;
    logic                   w_req_active;
    logic                   w_sys_reset;

    // div_cnt spans 0..2H-1 with H = PIX_DIV/2, so "div_cnt mod H == H-1"
    // reduces to two equality compares and needs no divider.
    assign w_ce_pix = (r_div_cnt == c_DIV_LAST);
    assign w_ce_vga = (r_div_cnt == c_HALF_LAST) || (r_div_cnt == c_DIV_LAST);

    assign w_cpu_last    = r_turbo_active ? c_CPU_LAST_TURBO : c_CPU_LAST_NORMAL;
    assign w_cpu_at_last = (r_cpu_cnt == w_cpu_last);
    assign w_ce_cpu      = w_ce_pix && w_cpu_at_last && !cpu_wait;

    assign w_any_req    = |r_req_sync;
    assign w_req_active = (r_deb_cnt == c_DEB_DONE);
    assign w_sys_reset  = (r_por_cnt != c_POR_DONE) || w_req_active;

    // ------------------------------------------------------------------------
    // Master divider: pixel and scandoubler enables
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_ce_pix) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Turbo request synchroniser
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_turbo_meta <= 1'b0;
            r_turbo_sync <= 1'b0;
        end else begin
            r_turbo_meta <= turbo;
            r_turbo_sync <= r_turbo_meta;
        end
    end

    // ------------------------------------------------------------------------
    // CPU divider
    // The active divisor only changes on a ce_cpu, where the counter also
    // restarts, so every CPU cycle is a whole number of pixel periods at a
    // single rate. While stalled the counter parks on its last value so the
    // enable is released on the first pixel enable after the stall ends.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_cnt      <= '0;
            r_turbo_active <= 1'b0;
        end else if (w_ce_cpu) begin
            r_cpu_cnt      <= '0;
            r_turbo_active <= r_turbo_sync;
        end else if (w_ce_pix && !w_cpu_at_last) begin
            r_cpu_cnt      <= r_cpu_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Reset request synchronisers and debounce
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_meta <= '0;
            r_req_sync <= '0;
        end else begin
            r_req_meta <= ~rst_req_n;
            r_req_sync <= r_req_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_cnt <= '0;
        end else if (!w_any_req) begin
            r_deb_cnt <= '0;
        end else if (!w_req_active) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Power-on / post-request reset stretch, timed in pixel enables.
    // Held at zero while a debounced request is active so that the full
    // stretch is applied after the last cause clears.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_por_cnt <= '0;
        end else if (w_req_active) begin
            r_por_cnt <= '0;
        end else if (w_ce_pix && (r_por_cnt != c_POR_DONE)) begin
            r_por_cnt <= r_por_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Enables are masked during master reset so that divider phases
    // which decode high at count 0 do not leak out while reset is held.
    // ------------------------------------------------------------------------
    assign ce_pix       = w_ce_pix && !reset;
    assign ce_vga       = w_ce_vga && !reset;
    assign ce_cpu       = w_ce_cpu && !reset;
    assign sys_reset    = w_sys_reset;
    assign core_reset_n = !w_sys_reset;
    assign turbo_active = r_turbo_active;

endmodule
`default_nettype wire

// File: tb/tb_ace_clock_reset_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ace_clock_reset_gen
// Description : Directed self-checking bench for ace_clock_reset_gen. A
//               default-parameter instance covers enables, turbo, wait,
//               debounce and mid-run reset; a second instance covers a
//               non-default parameter set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ace_clock_reset_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       reset, turbo, cpu_wait;
    logic [1:0] rst_req_n;
    logic       ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active;

    // parametrised instance
    logic       reset2, turbo2, cpu_wait2;
    logic [2:0] rst_req_n2;
    logic       ce_vga2, ce_pix2, ce_cpu2, sys_reset2, core_reset_n2, turbo_active2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ace_clock_reset_gen #(
        .PIX_DIV(4), .CPU_DIV_NORMAL(2), .CPU_DIV_TURBO(1),
        .POR_CYCLES(8), .NUM_RST_SRC(2), .DEB_CYCLES(16)
    ) u_dut (
        .clk(clk), .reset(reset), .rst_req_n(rst_req_n), .turbo(turbo),
        .cpu_wait(cpu_wait), .ce_vga(ce_vga), .ce_pix(ce_pix), .ce_cpu(ce_cpu),
        .sys_reset(sys_reset), .core_reset_n(core_reset_n),
        .turbo_active(turbo_active)
    );

    ace_clock_reset_gen #(
        .PIX_DIV(2), .CPU_DIV_NORMAL(3), .CPU_DIV_TURBO(1),
        .POR_CYCLES(1), .NUM_RST_SRC(3), .DEB_CYCLES(16)
    ) u_dut2 (
        .clk(clk), .reset(reset2), .rst_req_n(rst_req_n2), .turbo(turbo2),
        .cpu_wait(cpu_wait2), .ce_vga(ce_vga2), .ce_pix(ce_pix2), .ce_cpu(ce_cpu2),
        .sys_reset(sys_reset2), .core_reset_n(core_reset_n2),
        .turbo_active(turbo_active2)
    );

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Output bundle order: {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active}

    task automatic test_reset();
        logic [5:0] got;
        reset = 1'b1; turbo = 1'b0; cpu_wait = 1'b0; rst_req_n = 2'b11;
        reset2 = 1'b1; turbo2 = 1'b0; cpu_wait2 = 1'b0; rst_req_n2 = 3'b111;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active};
            checks++;
            if (got !== 6'b000100) begin
                errors++;
                $display("FAIL reset_state: got %b expected 000100", got);
            end
            tick();
        end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_defaults();
        logic [5:0] got, exp;
        while (cyc < 64) begin
            @(negedge clk);
            got = {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active};
            exp = {cyc % 2 == 1, cyc % 4 == 3, cyc % 8 == 7, cyc < 32, cyc >= 32, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL defaults cyc=%0d: got %b expected %b", cyc, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_turbo();
        logic [5:0] got, exp;
        logic       e_cpu;
        while (cyc < 176) begin
            if (cyc == 100) turbo = 1'b1;
            if (cyc == 140) turbo = 1'b0;
            @(negedge clk);
            if (cyc < 104)      e_cpu = (cyc % 8 == 7);
            else if (cyc < 144) e_cpu = (cyc % 4 == 3);
            else                e_cpu = (cyc % 8 == 7);
            got = {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active};
            exp = {cyc % 2 == 1, cyc % 4 == 3, e_cpu, 1'b0, 1'b1, (cyc >= 104 && cyc < 144)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL turbo cyc=%0d: got %b expected %b", cyc, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_wait();
        logic [5:0] got, exp;
        logic       e_cpu;
        while (cyc < 216) begin
            cpu_wait = (cyc >= 180 && cyc <= 192);
            @(negedge clk);
            if (cyc < 180) e_cpu = (cyc % 8 == 7);
            else           e_cpu = (cyc == 195) || (cyc > 195 && cyc % 8 == 3);
            got = {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active};
            exp = {cyc % 2 == 1, cyc % 4 == 3, e_cpu, 1'b0, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wait cyc=%0d: got %b expected %b", cyc, got, exp);
            end
            tick();
        end
        cpu_wait = 1'b0;
    endtask

    task automatic test_debounce();
        logic [5:0] got, exp;
        logic       e_rst;
        while (cyc < 352) begin
            rst_req_n[0] = !((cyc >= 216 && cyc <= 230) || (cyc >= 260 && cyc <= 299));
            @(negedge clk);
            e_rst = (cyc >= 278 && cyc <= 331);
            got = {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active};
            exp = {cyc % 2 == 1, cyc % 4 == 3, cyc % 8 == 3, e_rst, !e_rst, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL debounce cyc=%0d: got %b expected %b", cyc, got, exp);
            end
            tick();
        end
        rst_req_n = 2'b11;
    endtask

    task automatic test_reset_mid_turbo();
        logic [5:0] got, exp;
        logic       e_cpu;
        turbo = 1'b1;
        while (cyc < 370) begin
            @(negedge clk);
            e_cpu = (cyc < 356) ? (cyc % 8 == 3) : (cyc % 4 == 3);
            got = {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active};
            exp = {cyc % 2 == 1, cyc % 4 == 3, e_cpu, 1'b0, 1'b1, cyc >= 356};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_reset_turbo cyc=%0d: got %b expected %b", cyc, got, exp);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0;
        while (cyc < 48) begin
            @(negedge clk);
            e_cpu = (cyc == 7) || (cyc >= 8 && cyc % 4 == 3);
            got = {ce_vga, ce_pix, ce_cpu, sys_reset, core_reset_n, turbo_active};
            exp = {cyc % 2 == 1, cyc % 4 == 3, e_cpu, cyc < 32, cyc >= 32, cyc >= 8};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset_turbo cyc=%0d: got %b expected %b", cyc, got, exp);
            end
            tick();
        end
        turbo = 1'b0;
    endtask

    task automatic test_param();
        logic [5:0] got, exp;
        logic       e_rst;
        @(negedge clk);
        got = {ce_vga2, ce_pix2, ce_cpu2, sys_reset2, core_reset_n2, turbo_active2};
        checks++;
        if (got !== 6'b000100) begin
            errors++;
            $display("FAIL param_reset_state: got %b expected 000100", got);
        end
        tick();
        reset2 = 1'b0;
        cyc = 0;
        while (cyc < 60) begin
            rst_req_n2 = (cyc >= 30 && cyc <= 49) ? 3'b011 : 3'b111;
            @(negedge clk);
            e_rst = (cyc < 2) || (cyc >= 48 && cyc <= 53);
            got = {ce_vga2, ce_pix2, ce_cpu2, sys_reset2, core_reset_n2, turbo_active2};
            exp = {1'b1, cyc % 2 == 1, cyc % 6 == 5, e_rst, !e_rst, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL param cyc=%0d: got %b expected %b", cyc, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_turbo();
        test_wait();
        test_debounce();
        test_reset_mid_turbo();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
